// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and frame builder for the UART TX scheduler
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int WDOG_LIMIT = 12;

  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider; tick on the last count of each period
module uart_baud_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Not gated by clear, so a tick coinciding with the period that ends SHIFT is still seen.
  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin arbiter sharing one UART TX shifter among N_REQ requesters
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CLK_DIV  = 434,
  parameter int GAP_BITS = 1,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*8-1:0]    req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  tx_load,
  output logic [FRAME_BITS-1:0] tx_frame,
  output logic                  shift_en,
  output logic                  baud_tick,
  input  logic                  done,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam logic [3:0] WDOG_L   = 4'(WDOG_LIMIT);
  localparam logic [3:0] GAP_LAST = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [7:0]     r_data;
  logic [3:0]     r_wdog;
  logic [3:0]     r_gap_cnt;
  logic           r_err;
  logic           w_clear;
  logic           w_tick;
  logic           w_en;
  logic [IDW:0]   w_pick;
  logic [IDW-1:0] w_win;

  // Returns {found, index}: first set bit scanning circularly from ptr+1.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IDW-1:0] ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (v[idx]) begin
        r = {1'b1, IDW'(idx)};
      end
    end
    return r;
  endfunction

  assign w_pick = rr_pick(req_valid, r_rr_ptr);
  assign w_win  = w_pick[IDW-1:0];
  assign w_en   = (r_state == ST_SHIFT) || (r_state == ST_GAP);

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .en   (w_en),
    .tick (w_tick)
  );

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_clear   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[IDW]) begin
          req_ready[w_win] = 1'b1;
          w_next           = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_clear = 1'b1;
        w_next  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (done || (r_wdog == WDOG_L)) begin
          w_clear = 1'b1;
          w_next  = ST_GAP;
        end
      end
      ST_GAP: begin
        if ((GAP_BITS == 0) || (w_tick && (r_gap_cnt == GAP_LAST))) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= IDW'(N_REQ - 1);
      r_grant_id <= '0;
      r_data     <= '0;
      r_wdog     <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_SHIFT) && !done && (r_wdog == WDOG_L);
      if ((r_state == ST_IDLE) && w_pick[IDW]) begin
        r_rr_ptr   <= w_win;
        r_grant_id <= w_win;
        r_data     <= req_data[{w_win, 3'b000} +: 8];
      end
      if (r_state == ST_LOAD) begin
        r_wdog    <= '0;
        r_gap_cnt <= '0;
      end else if ((r_state == ST_SHIFT) && w_tick && (r_wdog != 4'hF)) begin
        r_wdog <= r_wdog + 1'b1;
      end else if ((r_state == ST_GAP) && w_tick) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  assign tx_load     = (r_state == ST_LOAD);
  assign tx_frame    = uart_frame(r_data);
  assign shift_en    = (r_state == ST_SHIFT);
  assign baud_tick   = shift_en && w_tick;
  assign busy        = (r_state != ST_IDLE);
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a reference arbiter/timing model
module tb_uart_tx_sched;

  localparam int N = 4, D = 4, G = 1, IW = 2;
  localparam int T_FALL = 10*D + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*8-1:0]  req_data;
  logic            tx_load, shift_en, baud_tick, done, busy, err_timeout;
  logic [9:0]      tx_frame;
  logic [IW-1:0]   grant_id;

  uart_tx_sched #(.N_REQ(N), .CLK_DIV(D), .GAP_BITS(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_load(tx_load), .tx_frame(tx_frame), .shift_en(shift_en), .baud_tick(baud_tick),
    .done(done), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [9:0] frame; int acc; int md; } exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // reference model state
  int m_last = N-1, m_free = 0, last_acc = 0, n_grant = 0;
  bit m_known = 1'b1;
  int mode = 0;                       // 0 normal, 1 no done (watchdog), 2 done with 10th tick
  int bc_mode = 0, bc_ticks = 0;
  bit bc_pend = 1'b0;
  logic [N-1:0] want = '0, acc_prev = '0, inj_mask = '0;
  logic [7:0] inj_byte = 8'h00;
  bit inj_rand = 1'b1;
  int p_on = 100, p_drop = 0;

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] exp_rdy;
    int w;
    bit idle;
    @(negedge clk);
    if (tx_load) begin bc_ticks = 0; bc_pend = 1'b0; end
    done = 1'b0;
    if (bc_pend) begin done = 1'b1; bc_pend = 1'b0; end
    if (shift_en && baud_tick) begin
      bc_ticks++;
      if (bc_ticks == 10 && bc_mode == 0) bc_pend = 1'b1;
      if (bc_ticks == 10 && bc_mode == 2) done = 1'b1;
    end
    if (!shift_en && !done && $urandom_range(0, 5) == 0) done = 1'b1;
    req_valid = req_valid & ~acc_prev;
    acc_prev = '0;
    for (int i = 0; i < N; i++) begin
      if (inj_mask[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = inj_rand ? 8'($urandom) : inj_byte;
      end else if (req_valid[i]) begin
        if (p_drop > 0 && $urandom_range(0, 99) < p_drop) req_valid[i] = 1'b0;
      end else if (want[i] && $urandom_range(0, 99) < p_on) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = 8'($urandom);
      end
    end
    inj_mask = '0;
    #1;
    if (!m_known && !busy) begin m_known = 1'b1; m_free = cyc; end
    idle = m_known && (cyc >= m_free);
    w = rr_next(req_valid, m_last);
    exp_rdy = '0;
    if (idle && w >= 0) exp_rdy[w] = 1'b1;
    if (m_known) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !idle);
    end
    if (exp_rdy != '0) begin
      sbq.push_back('{w, {1'b1, req_data[w*8 +: 8], 1'b0}, cyc, mode});
      m_last = w; bc_mode = mode; last_acc = cyc; n_grant++;
      acc_prev = exp_rdy;
      if (mode == 0) m_free = cyc + T_FALL + G*D;
      else if (mode == 2) m_free = cyc + T_FALL - 1 + G*D;
      else m_known = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    want = '0; p_drop = 0;
    while (!(m_known && cyc >= m_free && req_valid == '0 && sbq.size() == 0) && n < 2000) begin
      step(); n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 1);
    repeat (2) step();
  endtask

  task automatic run_grants(input int k);
    int target = n_grant + k, n = 0;
    while (n_grant < target && n < 2000) begin step(); n++; end
    if (n >= 2000) chk("grant_timeout", n_grant, target);
  endtask

  // monitor: pops expectations on tx_load and checks frame timing against the accept cycle
  initial begin
    int fa, fm, ticks, fall, errs;
    bit act, pse, pbusy;
    exp_t e;
    fa = 0; fm = 0; ticks = 0; fall = 0; errs = 0; act = 0; pse = 0; pbusy = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin act = 0; pse = 0; pbusy = 0; continue; end
      if (err_timeout) errs++;
      if (tx_load) begin
        if (sbq.size() == 0) chk("sb_empty_on_load", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("load_cycle", cyc, e.acc + 1);
          chk("grant_id", grant_id, e.id);
          chk("tx_frame", tx_frame, e.frame);
          fa = e.acc; fm = e.md; act = 1; ticks = 0; errs = 0;
        end
      end
      if (act && baud_tick) begin
        ticks++;
        chk("tick_cycle", cyc, fa + ticks*D + 1);
      end
      if (act && shift_en && !pse) chk("shift_rise", cyc, fa + 2);
      if (act && !shift_en && pse) begin
        fall = cyc;
        if (fm == 0) begin chk("shift_fall", cyc, fa + T_FALL); chk("ticks", ticks, 10); end
        else if (fm == 2) begin chk("coinc_fall", cyc, fa + T_FALL - 1); chk("coinc_ticks", ticks, 10); end
        else begin
          chk("wdog_ticks", ticks, 12);
          chk("wdog_fall_window", (cyc >= fa + 12*D + 2) && (cyc <= fa + 12*D + 3), 1);
        end
      end
      if (act && !busy && pbusy) begin
        chk("gap_len", cyc - fall, G*D);
        chk("err_pulses", errs, (fm == 1) ? 1 : 0);
        act = 0;
      end
      pse = shift_en; pbusy = busy;
    end
  end

  initial begin
    #(10*60000);
    chk("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1; done = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0; m_free = cyc;

    // single 0xA5 on requester 0
    inj_rand = 1'b0; inj_byte = 8'hA5; inj_mask = 4'b0001;
    step(); inj_rand = 1'b1;
    drain();

    // all requesters continuously valid
    want = 4'b1111; p_on = 100;
    run_grants(5);
    drain();

    // fairness between requesters 1 and 3 after a grant to 1
    inj_mask = 4'b0010; run_grants(1);
    want = 4'b1010; p_on = 100; run_grants(2);
    drain();

    // watchdog: no done for this frame
    mode = 1; inj_mask = 4'b0100; run_grants(1);
    drain(); mode = 0;
    inj_mask = 4'b0100; run_grants(1); drain();

    // done coincident with 10th tick
    mode = 2; inj_mask = 4'b1000; run_grants(1);
    drain(); mode = 0;

    // randomized traffic with withdrawals
    p_on = 20; p_drop = 3;
    for (int r = 0; r < 60; r++) begin
      want = 4'($urandom);
      repeat (50) step();
    end
    drain();

    // reset mid-SHIFT, tick cycle of the 5th bit
    inj_mask = 4'b0010; run_grants(1);
    n = 0;
    while (cyc < last_acc + 21 && n < 100) begin step(); n++; end
    chk("pre_rst_tick", baud_tick, 1);
    #2; rst = 1'b1; #1;
    chk("mid_rst_shift_en", shift_en, 0);
    chk("mid_rst_tick", baud_tick, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_load", tx_load, 0);
    done = 1'b0; req_valid = '0; sbq.delete(); bc_pend = 1'b0; acc_prev = '0;
    m_last = N-1; m_known = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_free = cyc;
    inj_mask = 4'b0101; run_grants(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit shifter and its bit counter among `N_REQ` byte requesters. It grants one requester at a time and frames the byte as 10 bits: a start bit, 8 data bits and a stop bit. It loads the frame into the shifter, then drives `shift_en` and a locally generated `baud_tick`. It waits for the counter's `done` pulse and enforces an inter-frame gap. It sits between the host-side requesters and the TX shifter/bit-counter pair.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `CLK_DIV`, 434: clk cycles per bit period, ≥ 2.
- `GAP_BITS`, 1: idle bit periods inserted after each frame, 0..15.

Ports:
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `req_valid` in, `N_REQ`: requester i has a byte pending; must hold until accepted.
- `req_data` in, `N_REQ*8`: byte for requester i at bits `[8i+7:8i]`; stable while valid.
- `req_ready` out, `N_REQ`: one-hot accept strobe; a byte is accepted when valid & ready.
- `tx_load` out, 1: single-cycle load strobe to the shifter.
- `tx_frame` out, 10: `{1'b1, data[7:0], 1'b0}`; valid while `tx_load` is high.
- `shift_en` out, 1: shifter/counter enable for the whole frame.
- `baud_tick` out, 1: single-cycle bit-period tick, only while `shift_en` is high.
- `done` in, 1: single-cycle pulse from the bit counter, one cycle after the 10th tick.
- `grant_id` out, `$clog2(N_REQ)`: index of the current or most recent winner.
- `busy` out, 1: high in every state except IDLE.
- `err_timeout` out, 1: single-cycle pulse when the frame watchdog fires.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP.
- **IDLE:** if any `req_valid` bit is set, the winner is the first set bit searched circularly from `rr_ptr+1`.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - Data is captured, `grant_id` and `rr_ptr` are updated to the winner, and the FSM goes to LOAD.
- **LOAD:** `tx_load`=1 for one cycle and `tx_frame` is driven. Divider and watchdog clear. Next state is SHIFT.
- **SHIFT:** `shift_en`=1.
  - Divider counts 0..CLK_DIV-1 from 0 on entry; `baud_tick`=1 when count==CLK_DIV-1, then the count wraps to 0.
  - Watchdog counts ticks, 4 bits, saturating.
  - On `done`, go to GAP.
  - If the watchdog reaches 12 without `done`: pulse `err_timeout` and go to GAP.
- **GAP:** `shift_en`=0. Wait `GAP_BITS` bit periods, i.e. GAP_BITS*CLK_DIV cycles, then go to IDLE. GAP_BITS=0 means a one-cycle pass to IDLE.
- `done` is ignored outside SHIFT.
- `done` coincident with `baud_tick`: the tick is still output and `done` wins the transition.
- Requester deasserting valid before grant is legal; it is simply not selected.
- Valid assertions during LOAD/SHIFT/GAP wait; there is no pre-fetch.
- Reset values: state IDLE, `rr_ptr`=N_REQ-1 so requester 0 has first priority, `grant_id`=0. All strobes, `shift_en`, `busy` and `err_timeout` are 0.

## Timing
- Accept in IDLE at cycle 0 → `tx_load` at cycle 1 → `shift_en` rises at cycle 2.
- First `baud_tick` at cycle CLK_DIV+1; k-th tick at cycle k*CLK_DIV+1.
- `done` is expected at cycle 10*CLK_DIV+2; `shift_en` falls the cycle after `done`.
- Next accept, earliest: cycle 10*CLK_DIV+3+GAP_BITS*CLK_DIV.
- `req_ready` is combinational in IDLE only. All other outputs are registered or decoded from state.
- `rst` mid-frame: all outputs drop immediately (asynchronous). No partial frame resumes.

## Structure
- Package `uart_pkg`:
  - state enum;
  - `FRAME_BITS`=10;
  - `WDOG_LIMIT`=12;
  - function `uart_frame(data)` returning the 10-bit frame.
- Sub-module `uart_baud_gen`:
  - parameter `CLK_DIV`;
  - inputs `clk`, `rst`, `clear`, `en`;
  - output `tick`;
  - reused for SHIFT ticks and GAP timing.
- Round-robin search is a combinational function inside the top module.

## Test plan
- Single request, CLK_DIV=4, GAP_BITS=1:
  - req0 sends 0xA5 at cycle 0 → `req_ready[0]` at cycle 0, `tx_frame`=10'b1_1010_0101_0 at cycle 1;
  - ticks at 5, 9, …, 41; `done` at 42; IDLE at 47.
- All 4 requesters valid continuously → grants in order 0,1,2,3,0; each frame separated by exactly GAP_BITS*CLK_DIV idle cycles.
- Fairness: req1 and req3 valid, last grant 1 → next grant is 3, then 1.
- Watchdog: `done` never driven → `err_timeout` pulses once after 12th tick, `shift_en` falls, FSM returns to IDLE, next request is served normally.
- `rst` asserted mid-SHIFT (cycle 20) → `shift_en`, `baud_tick`, `busy` are 0 asynchronously; after release, req0 wins first.
- Spurious `done` in IDLE/GAP, and `done` coincident with a tick → no state change in IDLE/GAP; the tick is still output in the coincident case.
